// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in over a WINDOW-cycle gate.
// Define RING_FREQ_METER_GLITCH_FILTER_EN to put a 3-sample majority filter ahead of the edge detector.
module ring_freq_meter #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             start,
    input  logic             abort,
    input  logic             meas_ack,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);

    state_t           state;
    state_t           next_state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] edge_cnt;
    logic [15:0]      win_cnt;
    logic             ovf;
    logic             win_end;
    logic             sat;

    // osc_in is asynchronous: two flops to resolve metastability, a third as edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef RING_FREQ_METER_GLITCH_FILTER_EN
    logic s4;
    logic maj;
    logic maj_q;

    assign maj = (s2 & s3) | (s2 & s4) | (s3 & s4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4    <= 1'b0;
            maj_q <= 1'b0;
        end else begin
            s4    <= s3;
            maj_q <= maj;
        end
    end

    assign rise = maj & ~maj_q;
`else
    assign rise = s2 & ~s3;
`endif

    assign win_end = (win_cnt == WIN_LAST);
    assign sat     = (edge_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ARM;
            ARM:     next_state = abort ? IDLE : COUNT;
            COUNT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (win_end) begin
                    next_state = DONE;
                end
            end
            DONE:    if (meas_ack) next_state = start ? ARM : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == ARM) || (state == COUNT);
        meas_valid = (state == DONE);
    end

    // The final window cycle's rise is folded straight into the published count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            win_cnt  <= '0;
            ovf      <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    edge_cnt <= '0;
                    win_cnt  <= '0;
                    ovf      <= 1'b0;
                end
                COUNT: begin
                    if (!abort) begin
                        win_cnt <= win_cnt + 16'd1;
                        if (rise) begin
                            if (sat) begin
                                ovf <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + CNT_W'(1);
                            end
                        end
                        if (win_end) begin
                            count    <= (rise && !sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
                            overflow <= ovf | (rise & sat);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_freq_meter.sv
// Randomized scoreboard bench for ring_freq_meter; the reference model counts rising edges of the
// planned osc_in sample stream (optionally majority-filtered) over the gate implied by start timing.
module tb_ring_freq_meter;
    localparam int WINDOW = 48;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int MAXC   = 20000;
`ifdef RING_FREQ_METER_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        int cnt;
        bit ovf;
        int done_cyc;
    } exp_t;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             osc_in   = 1'b0;
    logic             start    = 1'b0;
    logic             abort    = 1'b0;
    logic             meas_ack = 1'b0;
    logic             busy;
    logic             meas_valid;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   wav [0:MAXC-1];
    exp_t sb [$];
    int   last_cnt    = 0;
    bit   last_ovf    = 1'b0;

    ring_freq_meter #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .osc_in     (osc_in),
        .start      (start),
        .abort      (abort),
        .meas_ack   (meas_ack),
        .busy       (busy),
        .meas_valid (meas_valid),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // osc_in sampled at posedge n is always wav[n]
    initial begin
        forever begin
            @(negedge clk);
            #1;
            osc_in = (cyc + 1 < MAXC) ? wav[cyc + 1] : 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit xs(input int j);
        if (j < 0 || j >= MAXC) return 1'b0;
        return wav[j];
    endfunction

    function automatic bit ys(input int j);
        if (FILT) return (xs(j) & xs(j-1)) | (xs(j) & xs(j-2)) | (xs(j-1) & xs(j-2));
        return xs(j);
    endfunction

    // Start sampled at edge t: samples t..t+WINDOW-1 fall inside the gate (2-cycle sync + 1 count)
    function automatic exp_t predict(input int t);
        exp_t e;
        int   rises = 0;
        for (int j = t; j <= t + WINDOW - 1; j++) begin
            if (ys(j) && !ys(j-1)) rises++;
        end
        e.cnt      = (rises > CMAX) ? CMAX : rises;
        e.ovf      = (rises > CMAX);
        e.done_cyc = t + WINDOW + 1;
        return e;
    endfunction

    // Monitor: checks each result on entry to DONE and that it stays put while presented
    initial begin
        exp_t e;
        bit   mv_prev = 1'b0;
        int   held_cnt = 0;
        bit   held_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && meas_valid && !mv_prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_valid: got meas_valid=1, expected 0 (cycle %0d)", cyc);
                    held_cnt = int'(count);
                    held_ovf = overflow;
                end else begin
                    e = sb.pop_front();
                    checkOutput("count", count, e.cnt);
                    checkOutput("overflow", overflow, e.ovf);
                    checkOutput("done_cycle", cyc, e.done_cyc);
                    held_cnt = e.cnt;
                    held_ovf = e.ovf;
                end
            end else if (rst_n && meas_valid) begin
                checkOutput("held_count", count, held_cnt);
                checkOutput("held_overflow", overflow, held_ovf);
            end
            mv_prev = meas_valid;
        end
    end

    task automatic applyStimulus(input int mode, input int per, input int hi, input int ab_off,
                                 input int hold, input bit chain);
        int   t;
        int   ph;
        bit   got;
        exp_t e;
        @(negedge clk);
        t  = cyc + 1;
        ph = $urandom_range(0, per - 1);
        for (int k = 0; k < WINDOW + 12; k++) begin
            case (mode)
                0:       wav[t+k] = 1'b0;
                1:       wav[t+k] = (((k + ph) % per) < hi);
                2:       wav[t+k] = (k == WINDOW / 2);
                default: wav[t+k] = 1'($urandom_range(0, 1));
            endcase
        end
        e = predict(t);
        if (ab_off < 0) sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (ab_off >= 0) begin
            repeat (ab_off) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            #1;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_count", count, last_cnt);
            checkOutput("abort_overflow", overflow, last_ovf);
            repeat (3) @(negedge clk);
        end else begin
            got = 1'b0;
            for (int k = 0; k < WINDOW + 10; k++) begin
                if (meas_valid) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL valid_timeout: got no meas_valid, expected one by cycle %0d", e.done_cyc);
                sb.delete();
                return;
            end
            last_cnt = e.cnt;
            last_ovf = e.ovf;
            repeat (hold) begin
                start = 1'($urandom_range(0, 1));
                abort = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            start    = chain;
            abort    = 1'b0;
            meas_ack = 1'b1;
            @(negedge clk);
            meas_ack = 1'b0;
            start    = 1'b0;
            #1;
            checkOutput("ack_valid", meas_valid, 0);
            checkOutput("ack_busy", busy, chain);
            if (chain) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                #1;
                checkOutput("chain_abort_busy", busy, 0);
                checkOutput("chain_abort_count", count, last_cnt);
            end
        end
    endtask

    task automatic resetMidCount();
        @(negedge clk);
        for (int k = cyc + 1; k < cyc + WINDOW + 12; k++) wav[k] = (k % 4) < 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        for (int k = cyc + 1; k < cyc + WINDOW + 20; k++) wav[k] = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", meas_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        last_cnt = 0;
        last_ovf = 1'b0;
        repeat (50) begin
            @(negedge clk);
            checkOutput("post_rst_idle", {busy, meas_valid}, 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ab;
        int per;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("init_busy", busy, 0);
        checkOutput("init_valid", meas_valid, 0);
        checkOutput("init_count", count, 0);
        checkOutput("init_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(0, 3, 1, -1, 2, 1'b0);
        applyStimulus(1, 8, 4, -1, 1, 1'b0);
        applyStimulus(1, 3, 1, -1, 0, 1'b0);
        applyStimulus(1, 4, 2, -1, 20, 1'b0);
        applyStimulus(2, 3, 1, -1, 1, 1'b0);
        applyStimulus(1, 5, 2, 0, 0, 1'b0);
        applyStimulus(1, 5, 2, WINDOW, 0, 1'b0);
        applyStimulus(1, 6, 3, -1, 1, 1'b1);

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("idle_abort_busy", busy, 0);
        checkOutput("idle_abort_valid", meas_valid, 0);

        for (int i = 0; i < 30; i++) begin
            per = $urandom_range(3, 10);
            ab  = ($urandom_range(0, 9) < 3) ? $urandom_range(0, WINDOW) : -1;
            applyStimulus($urandom_range(0, 3), per, $urandom_range(1, per - 1), ab,
                          $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
        end

        resetMidCount();
        applyStimulus(1, 4, 2, -1, 1, 1'b0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
